// File: rtl/switch_bounce_gen.sv
// Mechanical-contact bounce emulator: drives sw_out through a bounded glitch burst before settling on target.
// Define SWITCH_BOUNCE_GEN_LFSR_EN to draw each glitch period from the LFSR instead of the fixed DWELL.
module switch_bounce_gen #(
    parameter int unsigned BOUNCE_LEN = 500000,
    parameter int unsigned DWELL      = 37,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic target,
    output logic sw_out,
    output logic busy,
    output logic done_tick
);

    localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [19:0] WIN_RELOAD = 20'(BOUNCE_LEN - 1);
    localparam logic [7:0]  DWELL_FIX  = 8'(DWELL - 1);
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BOUNCE = 2'b01
    } state_t;

    state_t      state;
    logic        level_reg;
    logic        new_level;
    logic [19:0] win;
    logic [7:0]  dwell;
    logic [15:0] lfsr;
    logic [7:0]  reload;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

`ifdef SWITCH_BOUNCE_GEN_LFSR_EN
    // Forcing bit 0 high keeps every glitch period odd and nonzero
    assign reload = {lfsr[7:1], 1'b1} - 8'd1;
`else
    assign reload = DWELL_FIX;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            level_reg <= 1'b0;
            new_level <= 1'b0;
            win       <= '0;
            dwell     <= '0;
            lfsr      <= LFSR_INIT;
            sw_out    <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            lfsr      <= lfsr_next(lfsr);
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (target != level_reg) begin
                        new_level <= target;
                        win       <= WIN_RELOAD;
                        dwell     <= reload;
                        sw_out    <= ~sw_out;
                        busy      <= 1'b1;
                        state     <= BOUNCE;
                    end else begin
                        sw_out <= level_reg;
                        busy   <= 1'b0;
                    end
                end
                BOUNCE: begin
                    if (target != new_level) begin
                        // A new command restarts the whole window, even if it returns to level_reg
                        new_level <= target;
                        win       <= WIN_RELOAD;
                        dwell     <= reload;
                        sw_out    <= ~sw_out;
                        busy      <= 1'b1;
                    end else if (win == 20'd0) begin
                        sw_out    <= new_level;
                        level_reg <= new_level;
                        done_tick <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        win <= win - 20'd1;
                        if (dwell == 8'd0) begin
                            sw_out <= ~sw_out;
                            dwell  <= reload;
                        end else begin
                            dwell <= dwell - 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    sw_out <= level_reg;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
